// File: rtl/intr_arbiter_ctrl_if.sv
// Bundle between the interrupt arbiter and its CPU side: raw requests, the intr/inta
// handshake, the in-service id/busy flags and the memory-mapped config port.
interface intr_arbiter_ctrl_if #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
);
  logic [NSRC-1:0] irq;
  logic            intr;
  logic            inta;
  logic [IDW-1:0]  irq_id;
  logic            busy;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     cfg_rdata;

  modport master (
    output irq, inta, cfg_we, cfg_addr, cfg_wdata,
    input  intr, irq_id, busy, cfg_rdata
  );

  modport slave (
    input  irq, inta, cfg_we, cfg_addr, cfg_wdata,
    output intr, irq_id, busy, cfg_rdata
  );
endinterface

// File: rtl/intr_arbiter_ctrl.sv
// Edge-capturing, maskable interrupt arbiter feeding the CPU's single intr line.
// Optional macro PRIO_ROTATE_EN switches fixed lowest-index priority to round-robin.
module intr_arbiter_ctrl #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic               clk,
  input  logic               clrn,
  intr_arbiter_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;
  localparam int         PW      = (IDW > 3) ? IDW : 3;
  localparam logic [NSRC-1:0] ONE = 1;

  logic [1:0]      state;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] irq_d;
  logic            intr_q;
  logic            busy_q;
  logic [IDW-1:0]  irq_id_q;

  logic [NSRC-1:0] req;
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] mask_nxt;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            eoi;
  logic            take;
  logic            withdraw;
  logic [31:0]     status;
  logic            unused_wdata;

`ifdef PRIO_ROTATE_EN
  logic [IDW-1:0]  ptr;
`endif

  assign eoi     = bus.cfg_we && (bus.cfg_addr == 2'd3);
  assign take    = (state == ST_REQ) && bus.inta;
  assign req     = pending & mask;
  assign set_vec = bus.irq & ~irq_d;

  // Upper write-data bits have no register behind them.
  assign unused_wdata = ^bus.cfg_wdata;

  always_comb begin
    clr_vec = '0;
    if (bus.cfg_we && (bus.cfg_addr == 2'd1))
      clr_vec = bus.cfg_wdata[NSRC-1:0];
    if (take)
      clr_vec = clr_vec | (ONE << irq_id_q);
  end

  // A new edge outranks any clear landing on the same cycle.
  assign pending_nxt = (pending & ~clr_vec) | set_vec;
  assign mask_nxt    = (bus.cfg_we && (bus.cfg_addr == 2'd0)) ? bus.cfg_wdata[NSRC-1:0] : mask;
  assign withdraw    = ~|(pending_nxt & mask_nxt & (ONE << irq_id_q));

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
`ifdef PRIO_ROTATE_EN
      idx = int'(ptr) + i;
      if (idx >= NSRC)
        idx = idx - NSRC;
`else
      idx = i;
`endif
      if (!found && req[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      mask     <= '0;
      pending  <= '0;
      irq_d    <= '0;
      intr_q   <= 1'b0;
      busy_q   <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_d   <= bus.irq;
      pending <= pending_nxt;
      mask    <= mask_nxt;
      case (state)
        ST_REQ: begin
          if (take) begin
            intr_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_SERV;
          end else if (withdraw) begin
            intr_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_SERV: begin
          if (eoi) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          // Encoding 3 is unreachable and behaves as IDLE.
          if (found) begin
            irq_id_q <= winner;
            intr_q   <= 1'b1;
            state    <= ST_REQ;
          end
        end
      endcase
    end
  end

`ifdef PRIO_ROTATE_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      ptr <= '0;
    else if (take)
      ptr <= (irq_id_q == IDW'(NSRC - 1)) ? '0 : irq_id_q + IDW'(1);
  end
`endif

  always_comb begin
    status                = '0;
    status[IDW-1:0]       = irq_id_q;
    status[PW+2 -: 2]     = state;
    status[PW+3]          = intr_q;
    status[PW+4]          = busy_q;
`ifdef PRIO_ROTATE_EN
    status[16 +: IDW]     = ptr;
`endif
  end

  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = 32'(mask);
      2'd1:    bus.cfg_rdata = 32'(pending);
      2'd2:    bus.cfg_rdata = status;
      default: bus.cfg_rdata = '0;
    endcase
  end

  assign bus.intr   = intr_q;
  assign bus.busy   = busy_q;
  assign bus.irq_id = irq_id_q;

endmodule

// File: tb/tb_intr_arbiter_ctrl.sv
// Randomized and directed bench for intr_arbiter_ctrl with a queue-based scoreboard
// fed by a cycle-level behavioural model.
module tb_intr_arbiter_ctrl;
  localparam int NSRC = 8;
  localparam int IDW  = 3;
  localparam int PW   = 3;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  intr_arbiter_ctrl_if #(.NSRC(NSRC), .IDW(IDW)) bus ();

  intr_arbiter_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           intr;
    logic [IDW-1:0] id;
    logic           busy;
    logic [31:0]    rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: phase 0=idle, 1=presenting, 2=in service
  bit m_pend[NSRC];
  bit m_mask[NSRC];
  bit m_prev[NSRC];
  int m_phase;
  int m_id;
  bit m_intr;
  bit m_busy;
  int m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
    m_phase = 0;
    m_id    = 0;
    m_intr  = 1'b0;
    m_busy  = 1'b0;
    m_ptr   = 0;
  endtask

  function automatic int pick();
    int start;
    int s;
    start = 0;
`ifdef PRIO_ROTATE_EN
    start = m_ptr;
`endif
    for (int k = 0; k < NSRC; k++) begin
      s = (start + k) % NSRC;
      if (m_pend[s] && m_mask[s])
        return s;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] addr);
    logic [31:0] v;
    v = 32'h0;
    case (addr)
      2'd0: for (int i = 0; i < NSRC; i++) v[i] = m_mask[i];
      2'd1: for (int i = 0; i < NSRC; i++) v[i] = m_pend[i];
      2'd2: begin
        v = 32'(m_id) | (32'(m_phase) << (PW + 1)) | (32'(m_intr) << (PW + 3))
          | (32'(m_busy) << (PW + 4));
`ifdef PRIO_ROTATE_EN
        v = v | (32'(m_ptr) << 16);
`endif
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic [NSRC-1:0] irqv, input logic inta, input logic we,
                            input logic [1:0] addr, input logic [31:0] wdata);
    bit np[NSRC];
    bit nm[NSRC];
    bit took;
    int w;
    took = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      np[i] = m_pend[i];
      nm[i] = m_mask[i];
      if (we && addr == 2'd0) nm[i] = wdata[i];
      if (we && addr == 2'd1 && wdata[i]) np[i] = 1'b0;
    end
    if (m_phase == 1 && inta) begin
      np[m_id] = 1'b0;
      took = 1'b1;
    end
    for (int i = 0; i < NSRC; i++)
      if (irqv[i] && !m_prev[i]) np[i] = 1'b1;
    case (m_phase)
      0: begin
        w = pick();
        if (w >= 0) begin
          m_id = w; m_intr = 1'b1; m_phase = 1;
        end
      end
      1: begin
        if (took) begin
          m_intr = 1'b0; m_busy = 1'b1; m_phase = 2;
          m_ptr = (m_id + 1) % NSRC;
        end else if (!(np[m_id] && nm[m_id])) begin
          m_intr = 1'b0; m_phase = 0;
        end
      end
      default: begin
        if (we && addr == 2'd3) begin
          m_busy = 1'b0; m_phase = 0;
        end
      end
    endcase
    m_pend = np;
    m_mask = nm;
    for (int i = 0; i < NSRC; i++) m_prev[i] = irqv[i];
  endtask

  // One clock: drive at negedge, push expectation, return 2ns after the edge.
  task automatic step(input logic [NSRC-1:0] irqv, input logic inta, input logic we,
                      input logic [1:0] addr, input logic [31:0] wdata);
    exp_t e;
    @(negedge clk);
    bus.irq = irqv; bus.inta = inta; bus.cfg_we = we;
    bus.cfg_addr = addr; bus.cfg_wdata = wdata;
    model_step(irqv, inta, we, addr, wdata);
    e.intr  = m_intr;
    e.id    = IDW'(m_id);
    e.busy  = m_busy;
    e.rdata = m_rdata(addr);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    bus.irq = '0; bus.inta = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = 2'd2; bus.cfg_wdata = '0;
    #1;
    check("rst_intr", 32'(bus.intr), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_status", bus.cfg_rdata, 32'h0);
    bus.cfg_addr = 2'd1; #1;
    check("rst_pending", bus.cfg_rdata, 32'h0);
    bus.cfg_addr = 2'd0; #1;
    check("rst_mask", bus.cfg_rdata, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // Monitor: compare every registered output just after each active edge
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sb_intr", 32'(bus.intr), 32'(mon_e.intr));
        check("sb_irq_id", 32'(bus.irq_id), 32'(mon_e.id));
        check("sb_busy", 32'(bus.busy), 32'(mon_e.busy));
        check("sb_rdata", bus.cfg_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NSRC-1:0] lvl;
    logic            ia;
    logic            we;
    logic [1:0]      ad;
    logic [31:0]     wd;
    int              r;

    bus.irq = '0; bus.inta = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
    model_reset();
    do_reset();

    // Basic flow
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'hFF);
    step(8'h08, 1'b0, 1'b0, 2'd1, 32'h0);
    check("basic_pending", bus.cfg_rdata, 32'h08);
    check("basic_intr_k", 32'(bus.intr), 32'h0);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    check("basic_intr", 32'(bus.intr), 32'h1);
    check("basic_id", 32'(bus.irq_id), 32'h3);
    step(8'h00, 1'b1, 1'b0, 2'd1, 32'h0);
    check("basic_ack_busy", 32'(bus.busy), 32'h1);
    check("basic_ack_pend", bus.cfg_rdata, 32'h0);
    step(8'h00, 1'b0, 1'b1, 2'd3, 32'h0);
    check("basic_eoi_busy", 32'(bus.busy), 32'h0);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    check("basic_idle_status", bus.cfg_rdata, 32'h03);

    // Priority and freeze
    step(8'h24, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h24, 1'b0, 1'b0, 2'd2, 32'h0);
`ifndef PRIO_ROTATE_EN
    check("prio_first", 32'(bus.irq_id), 32'h2);
`endif
    step(8'h25, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h25, 1'b0, 1'b0, 2'd2, 32'h0);
`ifndef PRIO_ROTATE_EN
    check("prio_frozen", 32'(bus.irq_id), 32'h2);
`endif
    step(8'h25, 1'b1, 1'b0, 2'd1, 32'h0);
    step(8'h25, 1'b0, 1'b1, 2'd3, 32'h0);
    step(8'h25, 1'b0, 1'b0, 2'd2, 32'h0);
`ifndef PRIO_ROTATE_EN
    check("prio_second", 32'(bus.irq_id), 32'h0);
`endif
    step(8'h25, 1'b1, 1'b0, 2'd1, 32'h0);
    step(8'h25, 1'b0, 1'b1, 2'd3, 32'h0);
    step(8'h25, 1'b0, 1'b0, 2'd2, 32'h0);
`ifndef PRIO_ROTATE_EN
    check("prio_third", 32'(bus.irq_id), 32'h5);
`endif
    step(8'h25, 1'b1, 1'b0, 2'd1, 32'h0);
    step(8'h25, 1'b0, 1'b1, 2'd3, 32'h0);

    // Masking and withdraw
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'h0);
    step(8'h02, 1'b0, 1'b0, 2'd1, 32'h0);
    check("mask_pending", bus.cfg_rdata, 32'h02);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    check("mask_no_intr", 32'(bus.intr), 32'h0);
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'h02);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    check("unmask_intr", 32'(bus.intr), 32'h1);
    check("unmask_id", 32'(bus.irq_id), 32'h1);
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'h0);
    check("withdraw_intr", 32'(bus.intr), 32'h0);
    step(8'h00, 1'b0, 1'b0, 2'd1, 32'h0);
    check("withdraw_pending", bus.cfg_rdata, 32'h02);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    check("withdraw_status", bus.cfg_rdata, 32'h01);

    // Same-cycle collisions
    step(8'h00, 1'b0, 1'b1, 2'd1, 32'hFF);
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'hFF);
    step(8'h10, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h10, 1'b1, 1'b0, 2'd1, 32'h0);
    check("coll_set_wins", bus.cfg_rdata, 32'h10);
    check("coll_busy", 32'(bus.busy), 32'h1);
    step(8'h10, 1'b0, 1'b1, 2'd3, 32'h0);
    step(8'h10, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h10, 1'b1, 1'b1, 2'd1, 32'h10);
    check("coll_inta_wins_busy", 32'(bus.busy), 32'h1);
    check("coll_inta_wins_intr", 32'(bus.intr), 32'h0);
    step(8'h00, 1'b0, 1'b1, 2'd3, 32'h0);

    // Reset while in service with two requests pending
    step(8'h00, 1'b0, 1'b1, 2'd1, 32'hFF);
    step(8'h01, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h01, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h01, 1'b1, 1'b0, 2'd2, 32'h0);
    step(8'h00, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h05, 1'b0, 1'b0, 2'd1, 32'h0);
    check("serv_pending", bus.cfg_rdata, 32'h05);
    check("serv_busy", 32'(bus.busy), 32'h1);
    do_reset();

`ifdef PRIO_ROTATE_EN
    // Round-robin pointer
    step(8'h00, 1'b0, 1'b1, 2'd0, 32'hFF);
    step(8'h42, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h42, 1'b0, 1'b0, 2'd2, 32'h0);
    check("rot_first", 32'(bus.irq_id), 32'h1);
    step(8'h42, 1'b1, 1'b0, 2'd2, 32'h0);
    check("rot_ptr2", (bus.cfg_rdata >> 16) & 32'hFF, 32'h2);
    step(8'h40, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h42, 1'b0, 1'b0, 2'd2, 32'h0);
    step(8'h42, 1'b0, 1'b1, 2'd3, 32'h0);
    step(8'h42, 1'b0, 1'b0, 2'd2, 32'h0);
    check("rot_second", 32'(bus.irq_id), 32'h6);
    step(8'h42, 1'b1, 1'b0, 2'd2, 32'h0);
    check("rot_ptr7", (bus.cfg_rdata >> 16) & 32'hFF, 32'h7);
    step(8'h42, 1'b0, 1'b1, 2'd3, 32'h0);
    do_reset();
`endif

    // Randomized traffic
    lvl = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 7) == 0) lvl[i] = ~lvl[i];
      ia = m_intr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      r  = $urandom_range(0, 15);
      we = 1'b0;
      ad = 2'($urandom_range(0, 3));
      wd = $urandom | $urandom;
      case (r)
        0: begin we = 1'b1; ad = 2'd0; end
        1: begin we = 1'b1; ad = 2'd1; wd = $urandom & $urandom; end
        2, 3: begin we = 1'b1; ad = 2'd3; end
        default: we = 1'b0;
      endcase
      step(lvl, ia, we, ad, wd);
    end

    @(posedge clk);
    #3;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intr_arbiter_ctrl.md
Name: intr_arbiter_ctrl

Overview:
- Programmable interrupt controller in front of the single-cycle CPU's single `intr` input.
- Collects NSRC external edge-triggered requests, applies a software mask, and picks one winner.
- Presents the winner to the CPU and holds it until the CPU takes it (`inta` pulse from the control unit).
- Then blocks further requests until software signals end-of-interrupt through a memory-mapped config port.

Parameters:
NSRC, 8, number of interrupt sources (2..32)
IDW, 3, width of winning-source id; must satisfy 2**IDW >= NSRC

Ports:
clk  input  1  system clock, rising edge
clrn  input  1  asynchronous active-low reset
irq  input  NSRC  raw request lines, rising-edge sensitive, already synchronous to clk
intr  output  1  interrupt request to CPU control unit
inta  input  1  one-cycle acknowledge from CPU control unit (CPU took the interrupt)
irq_id  output  IDW  id of the presented or in-service source
busy  output  1  high while an interrupt is in service (SERV state)
cfg_we  input  1  config write strobe
cfg_addr  input  2  config register select
cfg_wdata  input  32  config write data
cfg_rdata  output  32  config read data, combinational from cfg_addr

Behaviour:
Reset (clrn=0, immediate, any state, including mid-service):
- mask=0, pending=0, irq_d=0, state=IDLE, intr=0, irq_id=0, busy=0.

Edge capture:
- irq_d registers irq every cycle.
- pending[i] sets on the clock edge where irq[i]=1 and irq_d[i]=0.
- pending[i] clears on inta for i==irq_id, and on a W1C write to addr 1.
- Set and clear in the same cycle: set wins.

Config map (writes take effect at the clock edge):
- addr0: mask, RW, bits [NSRC-1:0]; upper bits read 0.
- addr1: pending. Read returns pending. Write is W1C.
- addr2: status, RO = {24'h0, busy, intr, state[1:0], 1'b0, irq_id padded to 3 bits}. For IDW>3, irq_id occupies bits [IDW-1:0] and the other fields shift up.
- addr3: EOI, write-only; any write is an eoi event; reads 0.

Arbitration:
- Fixed priority: lowest index wins among (pending & mask).

State machine, 2-bit encoding (IDLE=0, REQ=1, SERV=2; 3 unreachable, decodes to IDLE):
- IDLE:
  - If |(pending & mask): irq_id <= winner, intr <= 1, go REQ.
  - eoi ignored.
- REQ:
  - intr=1; irq_id frozen even if a higher-priority source becomes pending.
  - On inta: clear pending[irq_id], intr <= 0, busy <= 1, go SERV.
  - If pending[irq_id] & mask[irq_id] becomes 0 (W1C or mask write) without inta: intr <= 0, go IDLE (withdraw). Re-arbitration happens next cycle.
  - If inta and withdraw happen in the same cycle: inta wins.
- SERV:
  - intr=0; new edges still set pending.
  - On eoi: busy <= 0, go IDLE.
  - inta ignored.
  - irq_id holds the in-service id.

Latency:
- irq rising before edge k → pending=1 after k → intr=1 after k+1.
- eoi at edge m with something pending → intr=1 after m+1.

Other rules:
- An inta pulse outside REQ is ignored.
- Widths: winner encoder output is IDW bits. An index ≥ NSRC is never produced.

Optional Feature:
PRIO_ROTATE_EN
- Defined:
  - Round-robin priority using a rotation pointer ptr (IDW bits, reset 0).
  - Search starts at ptr and wraps modulo NSRC.
  - On each inta, ptr <= (irq_id+1) mod NSRC.
  - status bits [23:16] read ptr.
- Undefined:
  - Fixed lowest-index priority.
  - No ptr register exists; status bits [23:16] read 0.

Test Plan:
- Reset check: clrn=0 mid-SERV with pending=8'h05 → immediately intr=0, busy=0, pending=0, mask=0; cfg_rdata at addr2 = 0.
- Basic flow:
  - Stimulus: mask=8'hFF, pulse irq[3] at edge k.
  - Expected: pending=8'h08 after k; intr=1, irq_id=3 after k+1.
  - inta → intr=0, busy=1, pending=0.
  - EOI write → busy=0, state IDLE.
- Priority and freeze:
  - Stimulus: mask=8'hFF, irq[5] and irq[2] rise together.
  - Expected: irq_id=2 presented. irq[0] rising while in REQ → irq_id stays 2.
  - After inta and EOI: irq_id=0 presented next, then 5.
- Masking and withdraw:
  - Stimulus: mask=8'h00, pulse irq[1].
  - Expected: pending=8'h02, intr stays 0. Write mask=8'h02 → intr=1, irq_id=1.
  - Write mask=0 while in REQ → intr=0 next cycle, state IDLE, pending still 8'h02.
- Same-cycle collisions:
  - Stimulus: irq[4] re-rises in the same cycle inta clears pending[4].
  - Expected: pending[4] remains 1.
  - W1C addr1=8'h10 in the same cycle as inta → inta wins: SERV entered, busy=1.
- PRIO_ROTATE_EN:
  - Stimulus: sources 1 and 6 pending. First grant 1 (ptr=0).
  - Expected: ptr=2 after inta. Re-pend 1; after EOI, grant 6, not 1; then ptr=7.
